// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and output saturation helper for the conv datapath.
package conv_pkg;
    localparam int SIZE  = 23;
    localparam int DEPTH = 1024;
    localparam int GUARD = 5;
    localparam int IN_W  = 2*SIZE-1;
    localparam int ACC_W = IN_W + GUARD;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Clamp a widened signed value into the SIZE-bit signed output range.
    function automatic logic signed [SIZE-1:0] saturate(input logic signed [ACC_W:0] x);
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        hi = $signed({{(ACC_W+2-SIZE){1'b0}}, {(SIZE-1){1'b1}}});
        lo = $signed({{(ACC_W+2-SIZE){1'b1}}, {(SIZE-1){1'b0}}});
        if (x > hi)
            saturate = {1'b0, {(SIZE-1){1'b1}}};
        else if (x < lo)
            saturate = {1'b1, {(SIZE-1){1'b0}}};
        else
            saturate = x[SIZE-1:0];
    endfunction
endpackage

// File: rtl/conv_acc_ram.sv
// Simple dual-port partial-sum buffer with a one-cycle registered read, shaped for block RAM inference.
module conv_acc_ram
    import conv_pkg::*;
#(
    parameter int DATA_W = ACC_W,
    parameter int ADDR_W = AW,
    parameter int WORDS  = DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_acc.sv
// Cross-channel accumulator for conv partial sums: rescale, bias, optional ReLU, saturate, valid/ready out.
// Define CONV_ACC_ROUND_EN for round-half-up rescaling instead of a truncating floor shift.
module conv_acc
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [5:0]             chans,
    input  logic [AW-1:0]          matrix2,
    input  logic [SIZE-1:0]        bias,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE-1:0]        out_data,
    output logic [AW-1:0]          out_addr,
    output logic                   busy,
    output logic                   done
);
    state_t state, state_next;
    logic   done_next;

    logic [5:0]             chans_r, ch_cnt;
    logic [AW-1:0]          m2_r, pix_cnt;
    logic [SIZE-1:0]        bias_r;
    logic                   relu_r;

    logic                   accept, last_ch, last_pix, out_blocked, stall, wr_en;

    logic                   s1_valid, s1_first, s1_last;
    logic [AW-1:0]          s1_pix;
    logic [IN_W-1:0]        s1_data;

    logic                   fwd_valid;
    logic [ACC_W-1:0]       fwd_data;
    logic [ACC_W-1:0]       rd_data;

    logic [ACC_W-1:0]       base, acc;
    logic signed [ACC_W:0]  acc_ext, shifted, bias_ext, res;

`ifdef CONV_ACC_ROUND_EN
    localparam logic signed [ACC_W:0] ROUND_K = (ACC_W+1)'(1) <<< (SIZE-2);
`endif

    assign out_blocked = out_valid && !out_ready;
    assign in_ready    = (state == RUN) && !out_blocked;
    assign accept      = in_valid && in_ready;
    assign last_ch     = (ch_cnt == chans_r - 6'd1);
    assign last_pix    = (pix_cnt == m2_r - AW'(1));
    // A final-channel result waiting on a full output register freezes stage 2; in_ready is already low then.
    assign stall       = s1_valid && s1_last && out_blocked;
    assign wr_en       = s1_valid && !s1_last;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_ch && last_pix) state_next = DRAIN;
            DRAIN: begin
                if (!s1_valid && out_valid && out_ready) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chans_r <= '0;
            m2_r    <= '0;
            bias_r  <= '0;
            relu_r  <= 1'b0;
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (state == IDLE && start) begin
            chans_r <= chans;
            m2_r    <= matrix2;
            bias_r  <= bias;
            relu_r  <= relu_en;
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            if (last_pix) begin
                pix_cnt <= '0;
                ch_cnt  <= ch_cnt + 6'd1;
            end else begin
                pix_cnt <= pix_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_pix   <= '0;
            s1_data  <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= in_data;
                s1_pix   <= pix_cnt;
                s1_first <= (ch_cnt == 6'd0);
                s1_last  <= last_ch;
            end
        end
    end

    // The RAM returns old data when a read and write hit one address on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
        end else if (accept) begin
            fwd_valid <= wr_en && (s1_pix == pix_cnt);
            fwd_data  <= acc;
        end
    end

    always_comb begin
        base     = s1_first ? '0 : (fwd_valid ? fwd_data : rd_data);
        acc      = base + {{GUARD{s1_data[IN_W-1]}}, s1_data};
        acc_ext  = $signed({acc[ACC_W-1], acc});
`ifdef CONV_ACC_ROUND_EN
        acc_ext  = acc_ext + ROUND_K;
`endif
        shifted  = acc_ext >>> (SIZE-1);
        bias_ext = $signed({{(ACC_W+1-SIZE){bias_r[SIZE-1]}}, bias_r});
        res      = shifted + bias_ext;
        if (relu_r && res < 0)
            res = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (s1_valid && s1_last && !out_blocked) begin
            out_valid <= 1'b1;
            out_data  <= saturate(res);
            out_addr  <= s1_pix;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    conv_acc_ram #(
        .DATA_W (ACC_W),
        .ADDR_W (AW),
        .WORDS  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (s1_pix),
        .wdata (acc),
        .re    (accept),
        .raddr (pix_cnt),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_conv_acc.sv
// Scoreboard bench for conv_acc: a channel-sum reference model queues expected results, a monitor pops them.
// Compile with CONV_ACC_ROUND_EN defined to check the round-half-up build.
`timescale 1ns/1ps
module tb_conv_acc;
    localparam int     SIZE    = 23;
    localparam int     IN_W    = 2*SIZE-1;
    localparam longint OUT_MAX = (longint'(1) <<< (SIZE-1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) <<< (SIZE-1));

    typedef struct {
        longint data;
        int     addr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [5:0]      chans;
    logic [9:0]      matrix2;
    logic [SIZE-1:0] bias;
    logic            relu_en;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;
    logic [9:0]      out_addr;
    logic            busy;
    logic            done;

    exp_t            sb[$];
    int              checks     = 0;
    int              passed     = 0;
    int              out_count  = 0;
    int              ready_mode = 0;
    bit              hold_prev  = 1'b0;
    logic [SIZE-1:0] hold_data;
    logic [9:0]      hold_addr;

    conv_acc dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chans     (chans),
        .matrix2   (matrix2),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Result of one pixel from the sum of its per-channel products.
    function automatic longint refModel(input longint sum, input longint b, input bit relu);
        longint r;
        r = sum;
`ifdef CONV_ACC_ROUND_EN
        r = r + (longint'(1) <<< (SIZE-2));
`endif
        r = (r >>> (SIZE-1)) + b;
        if (relu && r < 0) r = 0;
        if (r > OUT_MAX) r = OUT_MAX;
        if (r < OUT_MIN) r = OUT_MIN;
        return r;
    endfunction

    function automatic longint randData();
        longint mag;
        mag = longint'($urandom) << $urandom_range(0, 11);
        return ($urandom_range(0, 1) != 0) ? -mag : mag;
    endfunction

    function automatic longint randBias();
        return longint'($urandom_range(0, 8388607)) - 64'sd4194304;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_output: got result at addr %0d, expected none", out_addr);
            end else begin
                e = sb.pop_front();
                checkOutput("out_data", longint'($signed(out_data)), e.data);
                checkOutput("out_addr", longint'(out_addr), longint'(e.addr));
            end
        end
    end

    always @(negedge clk) begin
        if (hold_prev && !rst) begin
            checkOutput("hold_valid", longint'(out_valid), 1);
            checkOutput("hold_data", longint'(out_data), longint'(hold_data));
            checkOutput("hold_addr", longint'(out_addr), longint'(hold_addr));
        end
        hold_prev = !rst && out_valid && !out_ready;
        hold_data = out_data;
        hold_addr = out_addr;
    end

    task automatic sendBeat(input longint v, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("[TB] FAIL beat_accept: in_ready stayed low for 500 cycles, expected acceptance");
        end
    endtask

    task automatic applyStimulus(input int nch, input int npix, input longint b, input bit relu,
                                 input bit use_const, input longint cval, input bit gaps, input bit restart);
        longint sums[];
        longint v;
        exp_t   e;
        bit     ok;
        bit     seen;
        sums = new[npix];
        foreach (sums[i]) sums[i] = 0;
        out_count = 0;
        chans   = 6'(nch);
        matrix2 = 10'(npix);
        bias    = SIZE'(b);
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < nch; c++) begin
            for (int p = 0; p < npix; p++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                v = use_const ? cval : randData();
                sums[p] += v;
                if (c == nch - 1) begin
                    e.data = refModel(sums[p], b, relu);
                    e.addr = p;
                    sb.push_back(e);
                end
                if (restart && c == 0 && p == 1) begin
                    start   = 1'b1;
                    chans   = 6'd5;
                    matrix2 = 10'd3;
                end
                sendBeat(v, ok);
                if (!ok) return;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        checkOutput("done_seen", longint'(seen), 1);
        checkOutput("busy_at_done", longint'(busy), 0);
        checkOutput("output_count", longint'(out_count), longint'(npix));
        checkOutput("scoreboard_empty", longint'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic backpressure();
        ready_mode = 2;
        fork
            applyStimulus(2, 6, 7, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            begin
                bit              got;
                logic [SIZE-1:0] d0;
                logic [9:0]      a0;
                got = 1'b0;
                for (int i = 0; i < 200 && !got; i++) begin
                    @(negedge clk);
                    got = out_valid;
                end
                checkOutput("bp_valid_seen", longint'(got), 1);
                d0 = out_data;
                a0 = out_addr;
                checkOutput("bp_first_addr", longint'(a0), 0);
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bp_stall_data", longint'(out_data), longint'(d0));
                    checkOutput("bp_stall_addr", longint'(out_addr), longint'(a0));
                    checkOutput("bp_in_ready", longint'(in_ready), 0);
                end
                ready_mode = 1;
            end
        join
        ready_mode = 0;
    endtask

    task automatic resetMidMap();
        bit ok;
        int spurious;
        chans   = 6'd2;
        matrix2 = 10'd4;
        bias    = '0;
        relu_en = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int p = 0; p < 3; p++) sendBeat(randData(), ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", longint'(out_valid), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_in_ready", longint'(in_ready), 0);
        checkOutput("rst_out_data", longint'(out_data), 0);
        checkOutput("rst_out_addr", longint'(out_addr), 0);
        checkOutput("rst_done", longint'(done), 0);
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || done || busy) spurious++;
        end
        checkOutput("rst_no_activity", longint'(spurious), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        chans    = '0;
        matrix2  = '0;
        bias     = '0;
        relu_en  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_data", longint'(out_data), 0);
        checkOutput("reset_out_addr", longint'(out_addr), 0);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_done", longint'(done), 0);
        checkOutput("reset_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        ready_mode = 0;
        applyStimulus(1, 4, 5, 1'b0, 1'b1, longint'(3) <<< 22, 1'b0, 1'b0);
        applyStimulus(1, 2, 2, 1'b1, 1'b1, -(longint'(10) <<< 22), 1'b0, 1'b0);
        applyStimulus(1, 2, 2, 1'b0, 1'b1, -(longint'(10) <<< 22), 1'b0, 1'b0);
        applyStimulus(3, 2, 0, 1'b0, 1'b1, longint'(1) <<< 43, 1'b0, 1'b0);
        applyStimulus(3, 2, 0, 1'b0, 1'b1, -(longint'(1) <<< 43), 1'b0, 1'b0);
        applyStimulus(1, 2, 0, 1'b0, 1'b1, longint'(1) <<< 21, 1'b0, 1'b0);

        backpressure();

        ready_mode = 1;
        for (int m = 0; m < 6; m++)
            applyStimulus($urandom_range(1, 8), $urandom_range(2, 16), randBias(),
                          1'($urandom_range(0, 1)), 1'b0, 0, 1'b1, 1'b0);
        applyStimulus(32, 3, randBias(), 1'b0, 1'b1, (longint'(1) <<< 44) - 1, 1'b1, 1'b0);
        applyStimulus(32, 3, randBias(), 1'b0, 1'b1, -(longint'(1) <<< 44), 1'b1, 1'b0);
        applyStimulus(2, 5, randBias(), 1'b0, 1'b0, 0, 1'b0, 1'b1);

        resetMidMap();
        applyStimulus(3, 4, randBias(), 1'b1, 1'b0, 0, 1'b1, 1'b0);

        ready_mode = 0;
        applyStimulus(4, 2, randBias(), 1'b0, 1'b0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
